// File: rtl/contrast_stretch_if.sv
// Pixel stream bundle for contrast_stretch.
// Input and output valid/ready channels carry RGB444 pixels.
interface contrast_stretch_if;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] pixel_in;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] pixel_out;

   modport master (
      output in_valid,
      output pixel_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  pixel_out
   );

   modport slave (
      input  in_valid,
      input  pixel_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output pixel_out
   );
endinterface

// File: rtl/contrast_stretch.sv
// Per-channel RGB444 contrast stretch, 3-stage pipeline.
// S1 clamp/subtract, S2 30*d+r, S3 divide by 2r and register.
module contrast_stretch (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        coef_load,
   input  logic [11:0] min_in,
   input  logic [11:0] max_in,
   contrast_stretch_if.slave px,
   output logic        busy
);

   logic [11:0] min_q, min_d;
   logic [11:0] max_q, max_d;

   logic            s1_v_q, s1_v_d;
   logic [2:0][3:0] s1_dv_q, s1_dv_d;
   logic [2:0][3:0] s1_r_q, s1_r_d;
   logic [2:0][3:0] s1_p_q, s1_p_d;
   logic [2:0]      s1_pt_q, s1_pt_d;

   logic            s2_v_q, s2_v_d;
   logic [2:0][8:0] s2_n_q, s2_n_d;
   logic [2:0][3:0] s2_r_q, s2_r_d;
   logic [2:0][3:0] s2_p_q, s2_p_d;
   logic [2:0]      s2_pt_q, s2_pt_d;

   logic            ov_q, ov_d;
   logic [11:0]     pix_q, pix_d;

   logic            adv;
   logic [2:0][3:0] mn, mx, pp, pc;
   logic [2:0][8:0] dvs, quo;

   assign adv          = ~ov_q | px.out_ready;
   assign px.in_ready  = adv;
   assign px.out_valid = ov_q;
   assign px.pixel_out = pix_q;
   assign busy         = s1_v_q | s2_v_q | ov_q;

   // Coefficients follow coef_load regardless of pipeline state
   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (coef_load) begin
         min_d = min_in;
         max_d = max_in;
      end
   end

   // S1: clamp into [min,max], subtract min, latch per-pixel range
   always_comb begin
      mn      = '0;
      mx      = '0;
      pp      = '0;
      pc      = '0;
      s1_v_d  = s1_v_q;
      s1_dv_d = s1_dv_q;
      s1_r_d  = s1_r_q;
      s1_p_d  = s1_p_q;
      s1_pt_d = s1_pt_q;
      for (int c = 0; c < 3; c++) begin
         mn[c] = min_q[4*c +: 4];
         mx[c] = max_q[4*c +: 4];
         pp[c] = px.pixel_in[4*c +: 4];
         pc[c] = (pp[c] < mn[c]) ? mn[c] :
                 (pp[c] > mx[c]) ? mx[c] : pp[c];
      end
      if (adv) begin
         s1_v_d = px.in_valid;
         if (px.in_valid) begin
            for (int c = 0; c < 3; c++) begin
               s1_dv_d[c] = pc[c] - mn[c];
               s1_r_d[c]  = mx[c] - mn[c];
               s1_p_d[c]  = pp[c];
               s1_pt_d[c] = (mx[c] <= mn[c]);
            end
         end
      end
   end

   // S2: numerator 30*d + r, which tops out at 465
   always_comb begin
      s2_v_d  = s2_v_q;
      s2_n_d  = s2_n_q;
      s2_r_d  = s2_r_q;
      s2_p_d  = s2_p_q;
      s2_pt_d = s2_pt_q;
      if (adv) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            for (int c = 0; c < 3; c++) begin
               s2_n_d[c]  = 9'(s1_dv_q[c]) * 9'd30
                          + 9'(s1_r_q[c]);
               s2_r_d[c]  = s1_r_q[c];
               s2_p_d[c]  = s1_p_q[c];
               s2_pt_d[c] = s1_pt_q[c];
            end
         end
      end
   end

   // S3: divide by 2r (rounds half up) or pass through degenerate channels
   always_comb begin
      dvs   = '0;
      quo   = '0;
      ov_d  = ov_q;
      pix_d = pix_q;
      for (int c = 0; c < 3; c++) begin
         dvs[c] = s2_pt_q[c] ? 9'd1 : {4'd0, s2_r_q[c], 1'b0};
         quo[c] = s2_n_q[c] / dvs[c];
      end
      if (adv) begin
         ov_d = s2_v_q;
         if (s2_v_q) begin
            for (int c = 0; c < 3; c++) begin
               pix_d[4*c +: 4] = s2_pt_q[c] ? s2_p_q[c]
                                            : quo[c][3:0];
            end
         end
      end
   end

   // State registers; reset gives identity coefficients and empty pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q   <= 12'h000;
         max_q   <= 12'hFFF;
         s1_v_q  <= 1'b0;
         s1_dv_q <= '0;
         s1_r_q  <= '0;
         s1_p_q  <= '0;
         s1_pt_q <= '0;
         s2_v_q  <= 1'b0;
         s2_n_q  <= '0;
         s2_r_q  <= '0;
         s2_p_q  <= '0;
         s2_pt_q <= '0;
         ov_q    <= 1'b0;
         pix_q   <= 12'h000;
      end else begin
         min_q   <= min_d;
         max_q   <= max_d;
         s1_v_q  <= s1_v_d;
         s1_dv_q <= s1_dv_d;
         s1_r_q  <= s1_r_d;
         s1_p_q  <= s1_p_d;
         s1_pt_q <= s1_pt_d;
         s2_v_q  <= s2_v_d;
         s2_n_q  <= s2_n_d;
         s2_r_q  <= s2_r_d;
         s2_p_q  <= s2_p_d;
         s2_pt_q <= s2_pt_d;
         ov_q    <= ov_d;
         pix_q   <= pix_d;
      end
   end

endmodule

// File: tb/tb_contrast_stretch.sv
// Scoreboard bench for contrast_stretch.
// Expected pixels are queued at acceptance and popped at output.
module tb_contrast_stretch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        coef_load = 1'b0;
   logic [11:0] min_in = '0;
   logic [11:0] max_in = '0;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [11:0] exp_q[$];
   logic [11:0] cmn = 12'h000;
   logic [11:0] cmx = 12'hFFF;

   contrast_stretch_if ifc ();

   contrast_stretch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .coef_load (coef_load),
      .min_in    (min_in),
      .max_in    (max_in),
      .px        (ifc.slave),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ch_model(
      input logic [3:0] p, input logic [3:0] lo, input logic [3:0] hi);
      int num, den;
      if (hi <= lo) return p;
      if (p <= lo) return 4'd0;
      if (p >= hi) return 4'd15;
      num = (int'(p) - int'(lo)) * 15;
      den = int'(hi) - int'(lo);
      return 4'((2 * num + den) / (2 * den));
   endfunction

   function automatic logic [11:0] model(
      input logic [11:0] p, input logic [11:0] lo, input logic [11:0] hi);
      return {ch_model(p[11:8], lo[11:8], hi[11:8]),
              ch_model(p[7:4], lo[7:4], hi[7:4]),
              ch_model(p[3:0], lo[3:0], hi[3:0])};
   endfunction

   // One clock of stimulus; records acceptance and output handshakes
   task automatic cycle(
      input  logic v, input logic [11:0] pix, input logic ordy,
      input  logic cl, input logic [11:0] lo, input logic [11:0] hi,
      input  logic [11:0] e,
      output logic acc, output logic oacc, output logic ov,
      output logic [11:0] opix);
      ifc.in_valid  = v;
      ifc.pixel_in  = pix;
      ifc.out_ready = ordy;
      coef_load     = cl;
      min_in        = lo;
      max_in        = hi;
      @(negedge clk);
      acc  = ifc.in_valid && ifc.in_ready;
      if (acc) exp_q.push_back(e);
      ov   = ifc.out_valid;
      oacc = ifc.out_valid && ordy;
      opix = ifc.pixel_out;
      @(posedge clk);
      #1;
      cyc++;
      if (cl) begin
         cmn = lo;
         cmx = hi;
      end
   endtask

   task automatic apply_reset();
      ifc.in_valid  = 1'b0;
      ifc.pixel_in  = '0;
      ifc.out_ready = 1'b1;
      coef_load     = 1'b0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      cmn = 12'h000;
      cmx = 12'hFFF;
   endtask

   task automatic test_reset();
      ifc.in_valid  = 1'b0;
      ifc.pixel_in  = '0;
      ifc.out_ready = 1'b1;
      coef_load     = 1'b0;
      rst_n         = 1'b0;
      #3;
      checks++;
      if (ifc.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid got %b exp 0", ifc.out_valid);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b exp 0", busy);
      end
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b exp 1", ifc.in_ready);
      end
      checks++;
      if (ifc.pixel_out !== 12'h000) begin
         errors++;
         $display("FAIL reset_pixel_out got %h exp 000", ifc.pixel_out);
      end
      apply_reset();
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_in_ready got %b exp 1", ifc.in_ready);
      end
   endtask

   task automatic test_identity();
      logic [11:0] pv[3];
      int acc_cyc[$];
      int a;
      logic acc, oacc, ov;
      logic [11:0] opix, e;
      int got = 0;
      pv[0] = 12'h000;
      pv[1] = 12'h7A3;
      pv[2] = 12'hFFF;
      for (int i = 0; i < 12; i++) begin
         cycle(i < 3, (i < 3) ? pv[i] : 12'h000, 1'b1, 1'b0,
               12'h0, 12'h0, (i < 3) ? pv[i] : 12'h000,
               acc, oacc, ov, opix);
         if (acc) acc_cyc.push_back(i);
         if (oacc) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL identity_extra got %h", opix);
            end else begin
               e = exp_q.pop_front();
               if (opix !== e) begin
                  errors++;
                  $display("FAIL identity_pixel got %h exp %h", opix, e);
               end
            end
            checks++;
            a = (acc_cyc.size() > 0) ? acc_cyc.pop_front() : -100;
            if (i - a != 3) begin
               errors++;
               $display("FAIL identity_latency got %0d exp 3", i - a);
            end
         end
      end
      checks++;
      if (got != 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL identity_count got %0d exp 3", got);
      end
   endtask

   task automatic test_stretch();
      logic [11:0] pv[3];
      logic [11:0] ev[3];
      logic acc, oacc, ov;
      logic [11:0] opix, e;
      int got = 0;
      pv[0] = 12'h666; ev[0] = 12'h888;
      pv[1] = 12'h111; ev[1] = 12'h000;
      pv[2] = 12'hFFF; ev[2] = 12'hFFF;
      cycle(1'b0, 12'h0, 1'b1, 1'b1, 12'h222, 12'hAAA, 12'h0,
            acc, oacc, ov, opix);
      for (int i = 0; i < 10; i++) begin
         cycle(i < 3, (i < 3) ? pv[i] : 12'h000, 1'b1, 1'b0,
               12'h0, 12'h0, (i < 3) ? ev[i] : 12'h000,
               acc, oacc, ov, opix);
         if (oacc) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stretch_extra got %h", opix);
            end else begin
               e = exp_q.pop_front();
               if (opix !== e) begin
                  errors++;
                  $display("FAIL stretch_pixel got %h exp %h", opix, e);
               end
            end
         end
      end
      checks++;
      if (got != 3) begin
         errors++;
         $display("FAIL stretch_count got %0d exp 3", got);
      end
   endtask

   task automatic test_degenerate();
      logic acc, oacc, ov;
      logic [11:0] opix, e;
      int got = 0;
      cycle(1'b0, 12'h0, 1'b1, 1'b1, 12'h505, 12'h5A5, 12'h0,
            acc, oacc, ov, opix);
      for (int i = 0; i < 8; i++) begin
         cycle(i == 0, 12'h3C7, 1'b1, 1'b0, 12'h0, 12'h0, 12'h3F7,
               acc, oacc, ov, opix);
         if (oacc) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL degen_extra got %h", opix);
            end else begin
               e = exp_q.pop_front();
               if (opix !== e) begin
                  errors++;
                  $display("FAIL degen_pixel got %h exp %h", opix, e);
               end
            end
         end
      end
      checks++;
      if (got != 1) begin
         errors++;
         $display("FAIL degen_count got %0d exp 1", got);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] pv[8];
      logic acc, oacc, ov, ordy, prev_stall;
      logic [11:0] opix, e, prev_pix;
      int sent = 0;
      int got = 0;
      int n = 0;
      prev_stall = 1'b0;
      prev_pix   = '0;
      for (int i = 0; i < 8; i++) pv[i] = 12'($urandom);
      cycle(1'b0, 12'h0, 1'b1, 1'b1, 12'h214, 12'hE9C, 12'h0,
            acc, oacc, ov, opix);
      while ((sent < 8 || got < 8) && n < 300) begin
         ordy = 1'($urandom_range(0, 1));
         cycle(sent < 8, (sent < 8) ? pv[sent] : 12'h000, ordy,
               1'b0, 12'h0, 12'h0,
               model((sent < 8) ? pv[sent] : 12'h000, cmn, cmx),
               acc, oacc, ov, opix);
         n++;
         if (acc) sent++;
         if (prev_stall) begin
            checks++;
            if (!ov || opix !== prev_pix) begin
               errors++;
               $display("FAIL bp_stable got %b/%h exp 1/%h",
                        ov, opix, prev_pix);
            end
         end
         prev_stall = ov && !ordy;
         prev_pix   = opix;
         if (oacc) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra got %h", opix);
            end else begin
               e = exp_q.pop_front();
               if (opix !== e) begin
                  errors++;
                  $display("FAIL bp_pixel got %h exp %h", opix, e);
               end
            end
         end
      end
      checks++;
      if (sent != 8 || got != 8) begin
         errors++;
         $display("FAIL bp_count got %0d/%0d exp 8/8", sent, got);
      end
   endtask

   task automatic test_coef_swap();
      logic acc, oacc, ov;
      logic [11:0] opix, e;
      int got = 0;
      apply_reset();
      cycle(1'b1, 12'h666, 1'b1, 1'b1, 12'h222, 12'hAAA, 12'h666,
            acc, oacc, ov, opix);
      for (int i = 0; i < 8; i++) begin
         cycle(i == 0, 12'h666, 1'b1, 1'b0, 12'h0, 12'h0, 12'h888,
               acc, oacc, ov, opix);
         if (oacc) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL swap_extra got %h", opix);
            end else begin
               e = exp_q.pop_front();
               if (opix !== e) begin
                  errors++;
                  $display("FAIL swap_pixel got %h exp %h", opix, e);
               end
            end
         end
      end
      checks++;
      if (got != 2) begin
         errors++;
         $display("FAIL swap_count got %0d exp 2", got);
      end
   endtask

   task automatic test_reset_mid();
      logic acc, oacc, ov;
      logic [11:0] opix, e;
      int got = 0;
      cycle(1'b0, 12'h0, 1'b1, 1'b1, 12'h222, 12'hAAA, 12'h0,
            acc, oacc, ov, opix);
      cycle(1'b1, 12'h666, 1'b1, 1'b0, 12'h0, 12'h0, 12'h888,
            acc, oacc, ov, opix);
      cycle(1'b1, 12'h777, 1'b1, 1'b0, 12'h0, 12'h0, 12'h000,
            acc, oacc, ov, opix);
      ifc.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ifc.out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_flush got %b/%b exp 0/0",
                  ifc.out_valid, busy);
      end
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_in_ready got %b exp 1", ifc.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      cmn = 12'h000;
      cmx = 12'hFFF;
      for (int i = 0; i < 10; i++) begin
         cycle(i == 4, 12'h7A3, 1'b1, 1'b0, 12'h0, 12'h0, 12'h7A3,
               acc, oacc, ov, opix);
         if (oacc) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL midrst_stale got %h", opix);
            end else begin
               e = exp_q.pop_front();
               if (opix !== e) begin
                  errors++;
                  $display("FAIL midrst_pixel got %h exp %h", opix, e);
               end
            end
         end
      end
      checks++;
      if (got != 1) begin
         errors++;
         $display("FAIL midrst_count got %0d exp 1", got);
      end
   endtask

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.pixel_in  = '0;
      ifc.out_ready = 1'b1;
      test_reset();
      test_identity();
      test_stretch();
      test_degenerate();
      test_back_to_back();
      test_coef_swap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cycles %0d exp under 20000", cyc);
      $fatal(1);
   end

endmodule

// File: doc/contrast_stretch.md
CONTRAST_STRETCH -- requirements
Module: contrast_stretch

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port coef_load  input  1  one-cycle pulse: capture min_in and max_in into the coefficient registers.
REQ-004 SHALL have port min_in  input  12  per-channel minimum, RGB444 with channel fields [11:8], [7:4] and [3:0].
REQ-005 SHALL have port max_in  input  12  per-channel maximum, same packing as min_in.
REQ-006 SHALL have port in_valid  input  1  pixel_in is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts pixel_in this cycle.
REQ-008 SHALL have port pixel_in  input  12  RGB444 source pixel.
REQ-009 SHALL have port out_valid  output  1  pixel_out is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts pixel_out.
REQ-011 SHALL have port pixel_out  output  12  stretched RGB444 pixel.
REQ-012 SHALL have port busy  output  1  high while any pipeline stage holds a valid pixel.

Function
REQ-013 SHALL treat the three channels independently, each as a 4-bit unsigned value, with identical logic per channel.
REQ-014 SHALL, for each channel with max>min, produce out = round_half_up((clamp(p,min,max)-min)*15/(max-min)), i.e. floor((30*d + r)/(2*r)) where d = clamp(p,min,max)-min and r = max-min.
REQ-015 SHALL clamp each channel: p<min gives 0; p>max gives 15.
REQ-016 SHALL pass the channel through unchanged (out = p) when max<=min for that channel; degenerate channels are decided independently.
REQ-017 SHALL use internal widths wide enough that no intermediate overflows; 30*d + r has a maximum of 465 and needs 9 bits.
REQ-018 SHALL implement a 3-stage pipeline: S1 clamp/subtract and capture r per pixel; S2 multiply (30*d + r); S3 divide/round and register the output.
REQ-019 SHALL have a latency of exactly 3 cycles from the in_valid&in_ready edge to out_valid when there is no stall.
REQ-020 SHALL sustain a throughput of 1 pixel/cycle when out_ready is held high.
REQ-021 SHALL use a global advance enable, adv = ~out_valid | out_ready; in_ready = adv; all stages shift only when adv=1.
REQ-022 SHALL, when adv=1, load each stage valid bit from the previous stage, with S1 loaded from in_valid, so bubbles propagate as invalid.
REQ-023 SHALL hold pixel_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL let the coefficient registers update on coef_load regardless of pipeline state.
REQ-025 SHALL have a pixel accepted in the same cycle as coef_load use the OLD coefficients; pixels accepted from the next cycle use the new ones.
REQ-026 SHALL carry per-pixel coefficient-derived values down the pipeline, so a coef_load never alters pixels already in flight.
REQ-027 SHALL ignore pixel_in when in_valid=0 or in_ready=0; there is no side effect.
REQ-028 SHALL drive busy = OR of the S1, S2 and S3 valid bits.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear all stage valid bits, so out_valid=0 and busy=0.
REQ-030 SHALL reset pixel_out to 0x000.
REQ-031 SHALL reset the coefficient min to 0x000 and max to 0xFFF, an identity mapping where out equals in.
REQ-032 SHALL drive in_ready=1 while in reset and immediately after deassertion.
REQ-033 SHALL, on reset mid-stream, discard in-flight pixels; no partial output is emitted after reset.

Verification
REQ-034 SHALL cover identity after reset: feed 0x000, 0x7A3 and 0xFFF -> outputs 0x000, 0x7A3 and 0xFFF, each 3 cycles after acceptance.
REQ-035 SHALL cover stretch: coef_load min 0x222 / max 0xAAA, then pixels 0x666, 0x111 and 0xFFF -> 0x888, 0x000 and 0xFFF.
REQ-036 SHALL cover degenerate channels: min 0x505 / max 0x5A5, pixel 0x3C7 -> R=3 passthrough, G=15 clamp, B=7 passthrough, giving 0x3F7.
REQ-037 SHALL cover back-pressure: stream 8 pixels with out_ready toggling at random -> all 8 pixels out in order, none dropped or duplicated, pixel_out stable while stalled.
REQ-038 SHALL cover coef swap in flight: accept pixel 0x666 under identity, coef_load 0x222/0xAAA in the same cycle, then accept 0x666 -> outputs 0x666 then 0x888.
REQ-039 SHALL cover reset mid-operation: assert rst_n low with 2 pixels in flight -> out_valid=0 and busy=0 at once, coefficients back to identity, and no stale output after release.
